mp_mem_arbiter: RTL and testbench

- Parametrised N-core front end for the shared single-port data memory of the multiprocessor system.
- Accepts one read/write request per core, arbitrates round-robin and issues one memory command at a time.
- Waits for read data under a bounded timeout and returns a tagged response (core id, data, error) to the cores.
- Successor to the fixed single-requester memory interface: it adds multiple requesters, fairness, response tagging and timeout detection.

---
 rtl/mp_mem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mp_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mp_mem_arbiter
// Round-robin front end that lets NUM_CORES cores share one single-port data
// memory. One request is granted at a time. The memory command is issued for
// exactly one cycle. A read then waits a bounded number of cycles for
// mem_valid_out. A tagged response (core id, data, error) goes back to the cores.
//
// Ports
//   clk, reset_n        : clock (posedge) and asynchronous active-low reset
//   req, core_we        : per-core request (held until granted) and op (1=write)
//   core_addr/core_wdata: flattened per-core address / write data, core i at
//                         [i*W +: W]
//   gnt                 : one-hot grant, one-cycle pulse
//   mem_read_en/write_en: one-cycle memory strobes
//   mem_addr/mem_data_in: memory address / write data
//   mem_data_out/valid  : memory read data and its valid strobe
//   rsp_*               : response pulse with core id, data and timeout flag
//   busy                : high whenever the arbiter is not idle
// All outputs are registered.
// -----------------------------------------------------------------------------
module mp_mem_arbiter #(
    parameter int  NUM_CORES  = 4,
    parameter int  ADDR_WIDTH = 11,
    parameter int  DATA_WIDTH = 8,
    parameter int  TIMEOUT    = 16,
    localparam int CID_W      = $clog2(NUM_CORES)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_CORES-1:0]            req,
    input  logic [NUM_CORES-1:0]            core_we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]            gnt,
    output logic                            mem_read_en,
    output logic                            mem_write_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_data_in,
    input  logic [DATA_WIDTH-1:0]           mem_data_out,
    input  logic                            mem_valid_out,
    output logic                            rsp_valid,
    output logic [CID_W-1:0]                rsp_core_id,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic                            busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CID_W-1:0] ID_LAST  = CID_W'(NUM_CORES - 1);
    localparam logic [CID_W:0]   N_EXT    = (CID_W + 1)'(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CID_W-1:0]       cur_id_q, cur_id_d;
    logic                   cur_we_q, cur_we_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CORES-1:0]   gnt_q, gnt_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [CID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;

    // Unpack the flattened per-core buses.
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CORES];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_CORES];

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
        assign addr_arr[gi]  = core_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = core_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first set req bit at or above rr_ptr, wrapping.
    // The sum is one bit wider so the wrap can be done by a single subtract.
    logic             win_found;
    logic [CID_W-1:0] win_id;

    always_comb begin
        logic [CID_W:0] sum;
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sum = {1'b0, rr_ptr_q} + (CID_W + 1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            if (!win_found && req[sum[CID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = sum[CID_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        cur_we_d    = cur_we_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d    = NUM_CORES'(1) << win_id;
                    wr_en_d  = core_we[win_id];
                    rd_en_d  = !core_we[win_id];
                    addr_d   = addr_arr[win_id];
                    wdata_d  = wdata_arr[win_id];
                    cur_id_d = win_id;
                    cur_we_d = core_we[win_id];
                    rr_ptr_d = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Valid data takes priority over a timeout on the same edge.
                if (mem_valid_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_data_d  = mem_data_out;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            cur_we_q    <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            cur_we_q    <= cur_we_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt          = gnt_q;
    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_core_id  = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mp_mem_arbiter
// Scoreboard bench for mp_mem_arbiter. The driver works out which core should
// win from the round-robin rule. It pushes the expected grant and response into
// queues. A separate monitor pops the queues and compares whenever the DUT pulses
// gnt or rsp_valid. A memory responder returns read data after a per-transaction
// latency that the driver chooses.
// -----------------------------------------------------------------------------
module tb_mp_mem_arbiter;

    localparam int N     = 4;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int T     = 16;
    localparam int CW    = $clog2(N);
    localparam int NEVER = 1000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req, core_we, gnt;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic              mem_read_en, mem_write_en, mem_valid_out;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_in, mem_data_out;
    logic              rsp_valid, rsp_err, busy;
    logic [CW-1:0]     rsp_core_id;
    logic [DW-1:0]     rsp_data;
    logic              resp_valid_r, stray_valid;

    always #5 clk = ~clk;

    assign mem_valid_out = resp_valid_r | stray_valid;

    mp_mem_arbiter #(
        .NUM_CORES (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .gnt          (gnt),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_valid_out(mem_valid_out),
        .rsp_valid    (rsp_valid),
        .rsp_core_id  (rsp_core_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          err;
        int            lat;   // cycles from grant pulse to response pulse
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    lq[$];

    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    int ref_rr   = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int gcyc     = 0;
    bit inflight = 1'b0;

    logic          tb_we    [N];
    logic [AW-1:0] tb_addr  [N];
    logic [DW-1:0] tb_wdata [N];
    int            tb_delay [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int rr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            core_we[i]               = tb_we[i];
            core_addr[i*AW +: AW]    = tb_addr[i];
            core_wdata[i*DW +: DW]   = tb_wdata[i];
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},    gnt, 0);
        chk({tag, "_rd_en"},  mem_read_en, 0);
        chk({tag, "_wr_en"},  mem_write_en, 0);
        chk({tag, "_addr"},   mem_addr, 0);
        chk({tag, "_wdata"},  mem_data_in, 0);
        chk({tag, "_rsp_v"},  rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_core_id, 0);
        chk({tag, "_rsp_d"},  rsp_data, 0);
        chk({tag, "_rsp_e"},  rsp_err, 0);
        chk({tag, "_busy"},   busy, 0);
    endtask

    // Serve every core in mask; each core drops req once it sees its grant.
    task automatic do_round(input logic [N-1:0] mask);
        logic [N-1:0] m;
        int           w, d;
        bit           got, ok;
        gexp_t        g;
        rexp_t        r;
        m = mask;
        @(negedge clk);
        pack();
        req = m;
        while (m != 0) begin
            w = pick(m, ref_rr);
            ref_rr = (w + 1) % N;
            g.gnt = N'(1) << w; g.we = tb_we[w]; g.addr = tb_addr[w]; g.wdata = tb_wdata[w];
            gq.push_back(g);
            r.id = w;
            if (tb_we[w]) begin
                ref_mem[tb_addr[w]] = tb_wdata[w];
                r.data = '0; r.err = 1'b0; r.lat = 1;
            end else begin
                d  = tb_delay[w];
                ok = (d >= 1 && d <= T);
                r.data = ok ? ref_mem[tb_addr[w]] : '0;
                r.err  = !ok;
                r.lat  = ok ? 1 + d : 1 + T;
                lq.push_back(d);
            end
            rq.push_back(r);
            got = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #1;
                if (gnt != 0) begin got = 1'b1; break; end
            end
            chk("gnt_wait_bound", got, 1);
            if (!got) begin req = '0; return; end
            m = m & ~gnt;
            m[w] = 1'b0;
            req = m;
        end
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rq.size() == 0) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("rsp_drain_bound", got, 1);
    endtask

    // Monitor: compare every DUT grant/response against the scoreboard.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!reset_n) begin
                inflight = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    $display("rsp core %0d data 0x%02h err %0b (expect core %0d data 0x%02h err %0b)",
                             rsp_core_id, rsp_data, rsp_err, e.id, e.data, e.err);
                    chk("rsp_id",      rsp_core_id, e.id);
                    chk("rsp_data",    rsp_data, e.data);
                    chk("rsp_err",     rsp_err, e.err);
                    chk("rsp_latency", cyc - gcyc, e.lat);
                end
                inflight = 1'b0;
            end
            if (gnt != 0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", gnt, 0);
                end else begin
                    gexp_t e;
                    e = gq.pop_front();
                    chk("gnt",    gnt, e.gnt);
                    chk("wr_en",  mem_write_en, e.we);
                    chk("rd_en",  mem_read_en, !e.we);
                    chk("m_addr", mem_addr, e.addr);
                    if (e.we) chk("m_wdata", mem_data_in, e.wdata);
                end
                gcyc     = cyc;
                inflight = 1'b1;
            end
            chk("busy", busy, inflight);
        end
    end

    // Memory responder: applies writes, answers reads after the chosen latency.
    initial begin
        int            d;
        logic [AW-1:0] a;
        resp_valid_r = 1'b0;
        mem_data_out = '0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_write_en) mem[mem_addr] = mem_data_in;
            if (reset_n && mem_read_en) begin
                d = (lq.size() > 0) ? lq.pop_front() : NEVER;
                a = mem_addr;
                if (d != NEVER) begin
                    repeat (d) @(negedge clk);
                    resp_valid_r = 1'b1;
                    mem_data_out = mem[a];
                    @(negedge clk);
                    resp_valid_r = 1'b0;
                    mem_data_out = DW'($urandom);
                end
            end
        end
    end

    initial begin
        gexp_t g;
        bit    got;
        int    d;
        reset_n = 1'b0; req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        stray_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            tb_we[i] = 1'b0; tb_addr[i] = '0; tb_wdata[i] = '0; tb_delay[i] = 1;
        end
        for (int a = 0; a < 2**AW; a++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            mem[a] = v; ref_mem[a] = v;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // All four cores read at once, latency 1: served 0,1,2,3.
        for (int i = 0; i < N; i++) begin
            tb_we[i] = 1'b0; tb_addr[i] = AW'($urandom); tb_delay[i] = 1;
        end
        do_round(4'b1111);

        // Core 2 writes 0xA5 to 0x155.
        tb_we[2] = 1'b1; tb_addr[2] = 11'h155; tb_wdata[2] = 8'hA5;
        do_round(4'b0100);

        // rr pointer now at 3: core 3 before core 0.
        tb_we[3] = 1'b0; tb_addr[3] = 11'h155; tb_delay[3] = 3;
        tb_we[0] = 1'b1; tb_addr[0] = 11'h020; tb_wdata[0] = 8'h5A;
        do_round(4'b1001);

        // Core 1 reads 0x7FF, data 0x3C after 5 cycles.
        mem[11'h7FF] = 8'h3C; ref_mem[11'h7FF] = 8'h3C;
        tb_we[1] = 1'b0; tb_addr[1] = 11'h7FF; tb_delay[1] = 5;
        do_round(4'b0010);

        // Core 0 read never answered: timeout error, then a normal write.
        tb_we[0] = 1'b0; tb_addr[0] = 11'h011; tb_delay[0] = NEVER;
        do_round(4'b0001);
        tb_we[2] = 1'b1; tb_addr[2] = 11'h033; tb_wdata[2] = 8'hC3;
        do_round(4'b0100);

        // Valid exactly on the timeout edge, and valid during ISSUE only.
        tb_we[3] = 1'b0; tb_addr[3] = 11'h044; tb_delay[3] = T;
        do_round(4'b1000);
        tb_we[1] = 1'b0; tb_addr[1] = 11'h055; tb_delay[1] = 0;
        do_round(4'b0010);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                tb_we[i]    = 1'($urandom_range(0, 1));
                tb_addr[i]  = AW'($urandom);
                tb_wdata[i] = DW'($urandom);
                d           = int'($urandom_range(0, T + 3));
                tb_delay[i] = (d > T) ? NEVER : d;
            end
            do_round(N'($urandom_range(1, 2**N - 1)));
        end

        // Reset in the middle of RD_WAIT: no response, stray valid ignored.
        tb_we[2] = 1'b0; tb_addr[2] = 11'h066;
        @(negedge clk);
        pack();
        req = 4'b0100;
        g.gnt = 4'b0100; g.we = 1'b0; g.addr = 11'h066; g.wdata = tb_wdata[2];
        gq.push_back(g);
        lq.push_back(NEVER);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (gnt != 0) begin got = 1'b1; break; end
        end
        chk("gnt_wait_bound", got, 1);
        req = '0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        gq.delete(); rq.delete(); lq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        ref_rr = 0;
        stray_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_reset", rsp_valid, 0);
            if (c == 1) stray_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            tb_we[i] = 1'b0; tb_addr[i] = AW'($urandom); tb_delay[i] = 2;
        end
        do_round(4'b1010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
